// File: rtl/i2s_pkg.sv
`default_nettype none
// ------------------------------------------------------------------
// Package : i2s_pkg
// Shared types and limits for the serial-audio clock generators.
// Rev     : 1.0
// ------------------------------------------------------------------
package i2s_pkg;

  typedef enum logic {
    WS_I2S = 1'b0,
    WS_DSP = 1'b1
  } ws_mode_t;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_RUN      = 2'd1,
    ST_STOPPING = 2'd2
  } cgen_state_t;

  localparam int MIN_DIV       = 2;
  localparam int MIN_SLOT_BITS = 8;
  localparam int MAX_SLOT_BITS = 32;

endpackage
`default_nettype wire

// File: rtl/sclk_div_core.sv
`default_nettype none
// ------------------------------------------------------------------
// Module : sclk_div_core
// Divides mclk down to sclk (low ceil(D/2), high floor(D/2)) with edge strobes.
// Rev    : 1.0
// ------------------------------------------------------------------
module sclk_div_core #(
  parameter int DIV_W = 8
) (
  input  logic             mclk,
  input  logic             rst_,
  input  logic             run,
  input  logic [DIV_W-1:0] div,
  output logic             sclk,
  output logic             sclk_rise,
  output logic             sclk_fall,
  output logic             wrap
);

  logic [DIV_W-1:0] r_cnt;
  logic [DIV_W-1:0] w_cnt_nxt;
  logic [DIV_W-1:0] w_half;
  logic             r_sclk;
  logic             r_rise;
  logic             r_fall;

  assign w_half    = div - (div >> 1);
  assign wrap      = (r_cnt == div - DIV_W'(1));
  assign w_cnt_nxt = wrap ? '0 : r_cnt + DIV_W'(1);

  // A new divisor only ever takes effect from count 0, so periods never get cut short.
  always_ff @(posedge mclk or negedge rst_) begin
    if (!rst_) begin
      r_cnt  <= '0;
      r_sclk <= 1'b0;
      r_rise <= 1'b0;
      r_fall <= 1'b0;
    end else if (!run) begin
      r_cnt  <= '0;
      r_sclk <= 1'b0;
      r_rise <= 1'b0;
      r_fall <= 1'b0;
    end else begin
      r_cnt  <= w_cnt_nxt;
      r_sclk <= (w_cnt_nxt >= w_half);
      r_rise <= (w_cnt_nxt == w_half);
      r_fall <= wrap;
    end
  end

  assign sclk      = r_sclk;
  assign sclk_rise = r_rise;
  assign sclk_fall = r_fall;

endmodule
`default_nettype wire

// File: rtl/sclk_ws_gen.sv
`default_nettype none
// ------------------------------------------------------------------
// Module : sclk_ws_gen
// Bit clock, word select and slot/bit tracking for I2S and DSP/TDM frames.
// Rev    : 1.0
// ------------------------------------------------------------------
module sclk_ws_gen
  import i2s_pkg::*;
#(
  parameter  int DIV_W  = 8,
  parameter  int MAX_CH = 8,
  localparam int CH_W   = (MAX_CH > 1) ? $clog2(MAX_CH) : 1
) (
  input  logic             mclk,
  input  logic             rst_,
  input  logic             en,
  input  logic [DIV_W-1:0] div,
  input  logic [5:0]       slot_bits,
  input  logic [CH_W:0]    num_ch,
  input  logic             ws_mode,
  output logic             sclk,
  output logic             sclk_rise,
  output logic             sclk_fall,
  output logic             ws,
  output logic [CH_W-1:0]  slot,
  output logic [4:0]       bit_idx,
  output logic             frame_start,
  output logic             busy,
  output logic             cfg_err
);

  localparam logic [CH_W:0] c_max_ch = (CH_W+1)'(MAX_CH);
  localparam logic [CH_W:0] c_one_ch = (CH_W+1)'(1);

  cgen_state_t      r_state, w_state_nxt;
  logic [DIV_W-1:0] r_div, w_div_nxt;
  logic [5:0]       r_sb, w_sb_nxt;
  logic [CH_W:0]    r_nc, w_nc_nxt;
  ws_mode_t         r_mode, w_mode_nxt;
  logic [4:0]       r_bit, w_bit_nxt;
  logic [CH_W-1:0]  r_slot, w_slot_nxt, w_eff_slot;
  logic             r_fs, w_fs_nxt;
  logic             r_ws, w_ws_nxt;
  logic             r_cfg_err;
  logic             w_legal, w_last_bit, w_last_slot, w_boundary;
  logic             w_sample, w_load, w_wrap, w_run;

  assign w_legal = (div >= DIV_W'(MIN_DIV))
                && (slot_bits >= 6'(MIN_SLOT_BITS))
                && (slot_bits <= 6'(MAX_SLOT_BITS))
                && (num_ch != '0) && (num_ch <= c_max_ch)
                && ((ws_mode_t'(ws_mode) == WS_DSP) || !num_ch[0]);

  assign w_last_bit  = ({1'b0, r_bit} == r_sb - 6'd1);
  assign w_last_slot = ({1'b0, r_slot} == r_nc - c_one_ch);
  assign w_boundary  = (r_state != ST_IDLE) && w_wrap && w_last_bit && w_last_slot;
  assign w_sample    = en && ((r_state == ST_IDLE) || w_boundary);
  assign w_load      = w_sample && w_legal;

  assign w_div_nxt  = w_load ? div : r_div;
  assign w_sb_nxt   = w_load ? slot_bits : r_sb;
  assign w_nc_nxt   = w_load ? num_ch : r_nc;
  assign w_mode_nxt = w_load ? ws_mode_t'(ws_mode) : r_mode;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (en && w_legal) w_state_nxt = ST_RUN;
      end
      ST_RUN, ST_STOPPING: begin
        if (w_boundary) w_state_nxt = (en && w_legal) ? ST_RUN : ST_IDLE;
        else            w_state_nxt = en ? ST_RUN : ST_STOPPING;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    w_bit_nxt  = r_bit;
    w_slot_nxt = r_slot;
    w_fs_nxt   = 1'b0;
    if ((w_state_nxt == ST_IDLE) || (r_state == ST_IDLE)) begin
      w_bit_nxt  = '0;
      w_slot_nxt = '0;
      w_fs_nxt   = (w_state_nxt != ST_IDLE);
    end else if (w_wrap) begin
      if (w_last_bit) begin
        w_bit_nxt  = '0;
        w_slot_nxt = w_last_slot ? '0 : r_slot + CH_W'(1);
      end else begin
        w_bit_nxt  = r_bit + 5'd1;
      end
      w_fs_nxt = w_boundary;
    end
  end

  // In I2S mode ws follows the slot that the *next* bit belongs to, giving the one-bit lead.
  always_comb begin
    w_eff_slot = w_slot_nxt;
    if ({1'b0, w_bit_nxt} == w_sb_nxt - 6'd1)
      w_eff_slot = ({1'b0, w_slot_nxt} == w_nc_nxt - c_one_ch) ? '0 : w_slot_nxt + CH_W'(1);
    if (w_state_nxt == ST_IDLE)
      w_ws_nxt = 1'b0;
    else if (w_mode_nxt == WS_DSP)
      w_ws_nxt = (w_slot_nxt == '0) && (w_bit_nxt == '0);
    else
      w_ws_nxt = ({1'b0, w_eff_slot} >= (w_nc_nxt >> 1));
  end

  always_ff @(posedge mclk or negedge rst_) begin
    if (!rst_) begin
      r_state   <= ST_IDLE;
      r_div     <= '0;
      r_sb      <= '0;
      r_nc      <= '0;
      r_mode    <= WS_I2S;
      r_bit     <= '0;
      r_slot    <= '0;
      r_fs      <= 1'b0;
      r_ws      <= 1'b0;
      r_cfg_err <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_div   <= w_div_nxt;
      r_sb    <= w_sb_nxt;
      r_nc    <= w_nc_nxt;
      r_mode  <= w_mode_nxt;
      r_bit   <= w_bit_nxt;
      r_slot  <= w_slot_nxt;
      r_fs    <= w_fs_nxt;
      r_ws    <= w_ws_nxt;
      if (w_sample) r_cfg_err <= !w_legal;
    end
  end

  // The divider is held cleared on the entry edge and on the edge that returns to IDLE.
  assign w_run = (r_state != ST_IDLE) && (w_state_nxt != ST_IDLE);

  sclk_div_core #(
    .DIV_W(DIV_W)
  ) u_div (
    .mclk      (mclk),
    .rst_      (rst_),
    .run       (w_run),
    .div       (r_div),
    .sclk      (sclk),
    .sclk_rise (sclk_rise),
    .sclk_fall (sclk_fall),
    .wrap      (w_wrap)
  );

  assign ws          = r_ws;
  assign slot        = r_slot;
  assign bit_idx     = r_bit;
  assign frame_start = r_fs;
  assign busy        = (r_state != ST_IDLE);
  assign cfg_err     = r_cfg_err;

endmodule
`default_nettype wire

// File: tb/tb_sclk_ws_gen.sv
`default_nettype none
// ------------------------------------------------------------------
// Module : tb_sclk_ws_gen
// Directed, table-driven bench for sclk_ws_gen.
// Rev    : 1.0
// ------------------------------------------------------------------
module tb_sclk_ws_gen;

  logic       mclk;
  logic       rst_;
  logic       en;
  logic [7:0] div;
  logic [5:0] slot_bits;
  logic [3:0] num_ch;
  logic       ws_mode;
  logic       sclk, sclk_rise, sclk_fall, ws;
  logic [2:0] slot;
  logic [4:0] bit_idx;
  logic       frame_start, busy, cfg_err;

  sclk_ws_gen #(
    .DIV_W  (8),
    .MAX_CH (8)
  ) dut (
    .mclk        (mclk),
    .rst_        (rst_),
    .en          (en),
    .div         (div),
    .slot_bits   (slot_bits),
    .num_ch      (num_ch),
    .ws_mode     (ws_mode),
    .sclk        (sclk),
    .sclk_rise   (sclk_rise),
    .sclk_fall   (sclk_fall),
    .ws          (ws),
    .slot        (slot),
    .bit_idx     (bit_idx),
    .frame_start (frame_start),
    .busy        (busy),
    .cfg_err     (cfg_err)
  );

  initial mclk = 1'b0;
  always #5 mclk = ~mclk;

  typedef struct {
    int div;
    int sb;
    int nc;
    int mode;
    int lo;
    int hi;
    int flen;
    int ws_hi;
    int ws_rise;
  } vec_t;

  vec_t vecs[6];
  int   n_checks = 0;
  int   n_fail   = 0;

  int m_n, m_rises, m_falls, m_ws_hi, m_ws_rise, m_max_slot, m_max_bit;
  int m_bad_runs, m_bad_strobe;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge mclk);
  endtask

  task automatic do_reset();
    rst_ = 1'b0;
    en   = 1'b0;
    tick();
    tick();
    rst_ = 1'b1;
    tick();
  endtask

  task automatic start_cfg(input int d, input int sb, input int nc, input int m);
    div       = 8'(d);
    slot_bits = 6'(sb);
    num_ch    = 4'(nc);
    ws_mode   = m[0];
    en        = 1'b1;
    tick();
  endtask

  // Called on a frame_start cycle; follows sclk until the next frame_start or until busy drops.
  task automatic measure_frame(input int lo, input int hi);
    int   run_len;
    logic prev, prev_ws;
    bit   done;
    m_n = 0; m_rises = 0; m_falls = 0; m_ws_hi = int'(ws); m_ws_rise = -1;
    m_max_slot = int'(slot); m_max_bit = int'(bit_idx);
    m_bad_runs = 0; m_bad_strobe = 0;
    run_len = 1; prev = sclk; prev_ws = ws; done = 1'b0;
    while (!done) begin
      tick();
      m_n++;
      if (sclk != prev) begin
        if (prev ? (run_len != hi) : (run_len != lo)) m_bad_runs++;
        run_len = 1;
      end else begin
        run_len++;
      end
      if (busy) begin
        if (sclk_rise != (sclk && !prev)) m_bad_strobe++;
        if (sclk_fall != (!sclk && prev)) m_bad_strobe++;
      end
      m_rises += int'(sclk_rise);
      m_falls += int'(sclk_fall);
      prev = sclk;
      if (frame_start || !busy) begin
        done = 1'b1;
      end else begin
        m_ws_hi += int'(ws);
        if (ws && !prev_ws && m_ws_rise < 0) m_ws_rise = m_n;
        if (int'(slot) > m_max_slot) m_max_slot = int'(slot);
        if (int'(bit_idx) > m_max_bit) m_max_bit = int'(bit_idx);
      end
      prev_ws = ws;
      if (m_n > 20000) done = 1'b1;
    end
  endtask

  initial begin
    int n, bad;
    vecs[0] = '{div: 4,   sb: 16, nc: 2, mode: 0, lo: 2,   hi: 2,   flen: 128,  ws_hi: 64,  ws_rise: 60};
    vecs[1] = '{div: 3,   sb: 8,  nc: 2, mode: 0, lo: 2,   hi: 1,   flen: 48,   ws_hi: 24,  ws_rise: 21};
    vecs[2] = '{div: 255, sb: 8,  nc: 2, mode: 1, lo: 128, hi: 127, flen: 4080, ws_hi: 255, ws_rise: 0};
    vecs[3] = '{div: 2,   sb: 32, nc: 8, mode: 1, lo: 1,   hi: 1,   flen: 512,  ws_hi: 2,   ws_rise: 0};
    vecs[4] = '{div: 5,   sb: 8,  nc: 1, mode: 1, lo: 3,   hi: 2,   flen: 40,   ws_hi: 5,   ws_rise: 0};
    vecs[5] = '{div: 2,   sb: 8,  nc: 4, mode: 0, lo: 1,   hi: 1,   flen: 64,   ws_hi: 32,  ws_rise: 30};

    rst_ = 1'b0; en = 1'b0; div = 8'd4; slot_bits = 6'd16; num_ch = 4'd2; ws_mode = 1'b0;
    tick();
    tick();
    chk("reset_outputs", int'({sclk, sclk_rise, sclk_fall, ws, slot, bit_idx,
                               frame_start, busy, cfg_err}), 0);
    rst_ = 1'b1;
    tick();

    for (int i = 0; i < 6; i++) begin
      do_reset();
      start_cfg(vecs[i].div, vecs[i].sb, vecs[i].nc, vecs[i].mode);
      chk($sformatf("v%0d_entry", i),
          int'(frame_start && busy && !sclk && slot == 3'd0 && bit_idx == 5'd0), 1);
      chk($sformatf("v%0d_entry_ws", i), int'(ws), vecs[i].mode);
      measure_frame(vecs[i].lo, vecs[i].hi);
      chk($sformatf("v%0d_frame_len", i), m_n, vecs[i].flen);
      chk($sformatf("v%0d_duty_runs_bad", i), m_bad_runs, 0);
      chk($sformatf("v%0d_strobe_bad", i), m_bad_strobe, 0);
      chk($sformatf("v%0d_rises", i), m_rises, vecs[i].sb * vecs[i].nc);
      chk($sformatf("v%0d_falls", i), m_falls, vecs[i].sb * vecs[i].nc);
      chk($sformatf("v%0d_ws_high_cycles", i), m_ws_hi, vecs[i].ws_hi);
      chk($sformatf("v%0d_max_slot", i), m_max_slot, vecs[i].nc - 1);
      chk($sformatf("v%0d_max_bit", i), m_max_bit, vecs[i].sb - 1);
      if (vecs[i].mode == 0)
        chk($sformatf("v%0d_ws_rise_at", i), m_ws_rise, vecs[i].ws_rise);
    end

    // Divisor change mid-frame: old period holds until the boundary.
    do_reset();
    start_cfg(4, 8, 2, 0);
    div = 8'd6;
    measure_frame(2, 2);
    chk("reprog_old_frame_len", m_n, 64);
    chk("reprog_old_runs_bad", m_bad_runs, 0);
    measure_frame(3, 3);
    chk("reprog_new_frame_len", m_n, 96);
    chk("reprog_new_runs_bad", m_bad_runs, 0);

    // Stop request mid-frame completes the frame, then idles.
    do_reset();
    start_cfg(2, 8, 2, 0);
    en = 1'b0;
    measure_frame(1, 1);
    chk("stop_frame_len", m_n, 32);
    chk("stop_busy_at_boundary", int'(busy), 0);
    chk("stop_sclk_at_boundary", int'(sclk), 0);
    bad = 0;
    for (int k = 0; k < 12; k++) begin
      tick();
      if (sclk || sclk_rise || sclk_fall || busy || ws) bad++;
    end
    chk("stop_idle_activity", bad, 0);

    // en dropped then re-raised mid-frame: no gap.
    do_reset();
    start_cfg(2, 8, 2, 0);
    n = 0; bad = 0;
    do begin
      tick();
      n++;
      if (!busy) bad++;
      if (n == 3) en = 1'b0;
      if (n == 8) en = 1'b1;
    end while (!frame_start && n < 200);
    chk("resume_frame_len", n, 32);
    chk("resume_busy_gap", bad, 0);

    // Illegal configurations.
    do_reset();
    start_cfg(1, 8, 2, 0);
    chk("div1_cfg_err", int'(cfg_err), 1);
    bad = 0;
    for (int k = 0; k < 16; k++) begin
      tick();
      if (sclk || sclk_rise || sclk_fall || busy) bad++;
    end
    chk("div1_no_activity", bad, 0);
    do_reset();
    chk("cfg_err_reset", int'(cfg_err), 0);
    start_cfg(4, 8, 3, 0);
    chk("odd_ch_cfg_err", int'(cfg_err), 1);
    chk("odd_ch_busy", int'(busy), 0);
    num_ch = 4'd2;
    tick();
    chk("legal_cfg_err_clear", int'(cfg_err), 0);
    chk("legal_entry", int'(busy && frame_start), 1);

    // Asynchronous reset mid-slot, then clean restart.
    do_reset();
    start_cfg(4, 16, 2, 1);
    for (int k = 0; k < 37; k++) tick();
    #2 rst_ = 1'b0;
    #1;
    chk("async_reset_outputs", int'({sclk, sclk_rise, sclk_fall, ws, slot, bit_idx,
                                     frame_start, busy, cfg_err}), 0);
    tick();
    rst_ = 1'b1;
    tick();
    chk("restart_entry",
        int'(frame_start && busy && !sclk && slot == 3'd0 && bit_idx == 5'd0), 1);
    chk("restart_ws", int'(ws), 1);
    measure_frame(2, 2);
    chk("restart_frame_len", m_n, 128);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
